// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes, default field widths,
// a packed A-beat record and the repeater state encoding.
package tl_pkg;

  // Default A-channel field widths.
  localparam int A_ADDR_W = 31;
  localparam int A_SRC_W  = 7;
  localparam int A_DATA_W = 64;
  localparam int A_MASK_W = A_DATA_W / 8;

  // A-channel opcodes.
  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITH       = 3'd2,
    A_LOGIC       = 3'd3,
    A_GET         = 3'd4,
    A_HINT        = 3'd5,
    A_ACQUIRE     = 3'd6
  } a_opcode_e;

  // One A-channel beat at the default widths, most significant field first.
  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [2:0]          size;
    logic [A_SRC_W-1:0]  source;
    logic [A_ADDR_W-1:0] address;
    logic [A_MASK_W-1:0] mask;
    logic [A_DATA_W-1:0] data;
    logic                corrupt;
  } a_beat_t;

  // Repeater occupancy: EMPTY passes beats through, HELD replays the saved one.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } rpt_state_e;

endpackage

// File: rtl/tl_a_repeater.sv
// TileLink A-channel repeater. A beat accepted while repeat_en is high is
// captured and replayed downstream until a downstream handshake with
// repeat_en low releases it. While empty, beats pass through with no latency.
//
// Handshake: a beat transfers on a channel in any cycle where valid and ready
// are both high. Once valid is raised it stays high with a stable payload until
// that transfer happens; ready may be driven combinationally from the other side.
module tl_a_repeater
  import tl_pkg::*;
#(
  parameter int ADDR_W = 31,
  parameter int SRC_W  = 7,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                repeat_en,
  output logic                full,
  output logic                dbg_state,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [2:0]          enq_opcode,
  input  logic [2:0]          enq_param,
  input  logic [2:0]          enq_size,
  input  logic [SRC_W-1:0]    enq_source,
  input  logic [ADDR_W-1:0]   enq_address,
  input  logic [DATA_W/8-1:0] enq_mask,
  input  logic [DATA_W-1:0]   enq_data,
  input  logic                enq_corrupt,
  output logic                deq_valid,
  input  logic                deq_ready,
  output logic [2:0]          deq_opcode,
  output logic [2:0]          deq_param,
  output logic [2:0]          deq_size,
  output logic [SRC_W-1:0]    deq_source,
  output logic [ADDR_W-1:0]   deq_address,
  output logic [DATA_W/8-1:0] deq_mask,
  output logic [DATA_W-1:0]   deq_data,
  output logic                deq_corrupt
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PAY_W  = 3 + 3 + 3 + SRC_W + ADDR_W + MASK_W + DATA_W + 1;

  rpt_state_e        state_q;
  rpt_state_e        state_d;
  logic [PAY_W-1:0]  saved_q;
  logic [PAY_W-1:0]  enq_pay;
  logic [PAY_W-1:0]  deq_pay;
  logic              enq_fire;
  logic              deq_fire;
  logic              load_saved;

  // Whole beat flattened so capture and replay treat every field identically.
  assign enq_pay = {enq_opcode, enq_param, enq_size, enq_source,
                    enq_address, enq_mask, enq_data, enq_corrupt};

  assign full      = (state_q == ST_HELD);
  assign dbg_state = full;

  // Upstream is blocked while a beat is held, otherwise it sees downstream ready.
  assign enq_ready = deq_ready & ~full;
  assign deq_valid = enq_valid | full;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  // Capture only on the EMPTY->HELD step; enq_ready is low while HELD anyway,
  // but the state term makes the one-shot load explicit.
  assign load_saved = (state_q == ST_EMPTY) & enq_fire & repeat_en;

  // Held beat replays from the register, otherwise the live beat goes straight through.
  assign deq_pay = full ? saved_q : enq_pay;

  assign {deq_opcode, deq_param, deq_size, deq_source,
          deq_address, deq_mask, deq_data, deq_corrupt} = deq_pay;

  // State register; reset drops any held beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter HELD on a repeated accept, leave on a non-repeated replay.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (enq_fire && repeat_en) begin
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (deq_fire && !repeat_en) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Saved beat register, cleared on reset and loaded once per hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saved_q <= '0;
    end else if (load_saved) begin
      saved_q <= enq_pay;
    end
  end

endmodule

// File: tb/tb_tl_a_repeater.sv
// Bench for tl_a_repeater: reset checks, a table of pass-through vectors,
// hand-written multi-cycle sequences, and randomized traffic against a
// queue-based model with a valid-hold monitor on the downstream side.
module tb_tl_a_repeater;
  import tl_pkg::*;

  localparam int ADDR_W = 31;
  localparam int SRC_W  = 7;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic              rep;
  logic              full;
  logic              dbg_state;
  logic              enq_valid;
  logic              enq_ready;
  logic              deq_valid;
  logic              deq_ready;
  a_beat_t           drv;
  a_beat_t           deq_b;
  logic [2:0]        deq_opcode, deq_param, deq_size;
  logic [SRC_W-1:0]  deq_source;
  logic [ADDR_W-1:0] deq_address;
  logic [MASK_W-1:0] deq_mask;
  logic [DATA_W-1:0] deq_data;
  logic              deq_corrupt;

  assign deq_b = {deq_opcode, deq_param, deq_size, deq_source,
                  deq_address, deq_mask, deq_data, deq_corrupt};

  tl_a_repeater #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .repeat_en   (rep),
    .full        (full),
    .dbg_state   (dbg_state),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_opcode  (drv.opcode),
    .enq_param   (drv.param),
    .enq_size    (drv.size),
    .enq_source  (drv.source),
    .enq_address (drv.address),
    .enq_mask    (drv.mask),
    .enq_data    (drv.data),
    .enq_corrupt (drv.corrupt),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_opcode  (deq_opcode),
    .deq_param   (deq_param),
    .deq_size    (deq_size),
    .deq_source  (deq_source),
    .deq_address (deq_address),
    .deq_mask    (deq_mask),
    .deq_data    (deq_data),
    .deq_corrupt (deq_corrupt)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- driver helpers ----------------
  function automatic a_beat_t rand_beat();
    a_beat_t b;
    b.opcode  = 3'($urandom_range(0, 6));
    b.param   = 3'($urandom_range(0, 7));
    b.size    = 3'($urandom_range(0, 7));
    b.source  = SRC_W'($urandom);
    b.address = ADDR_W'($urandom);
    b.mask    = MASK_W'($urandom);
    b.data    = {$urandom, $urandom};
    b.corrupt = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic a_beat_t mk_beat(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                                      input logic [SRC_W-1:0] src, input logic [DATA_W-1:0] dat);
    a_beat_t b;
    b         = '0;
    b.opcode  = op;
    b.size    = 3'd2;
    b.source  = src;
    b.address = addr;
    b.mask    = '1;
    b.data    = dat;
    return b;
  endfunction

  task automatic drive(input logic ev, input logic dr, input logic rp, input a_beat_t b);
    enq_valid = ev;
    deq_ready = dr;
    rep       = rp;
    drv       = b;
  endtask

  // Advance from the sampling point to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // ---------------- downstream valid-hold monitor ----------------
  bit      mon_en    = 1'b0;
  bit      mon_stall = 1'b0;
  a_beat_t mon_beat;

  always @(negedge clock) begin
    if (mon_en && mon_stall) begin
      chk("mon_valid_hold", 128'(deq_valid), 128'(1'b1));
      chk("mon_payload_hold", 128'(deq_b), 128'(mon_beat));
    end
    mon_stall = mon_en && deq_valid && !deq_ready;
    mon_beat  = deq_b;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic ev;
    logic dr;
    logic rp;
    logic exp_dv;
    logic exp_er;
    logic exp_full_next;
  } vec_t;

  vec_t vecs[7];

  // ---------------- reference model state ----------------
  a_beat_t held_q[$];

  a_beat_t b_exp;
  a_beat_t b_other;
  logic    exp_dv, exp_er;
  bit      up_stall;

  initial begin
    drive(1'b0, 1'b1, 1'b0, '0);

    // Reset state, including the combinational follow-through while in reset.
    #2;
    chk("reset_full", 128'(full), 128'(1'b0));
    chk("reset_deq_valid", 128'(deq_valid), 128'(1'b0));
    chk("reset_enq_ready", 128'(enq_ready), 128'(1'b1));
    chk("reset_saved_zero", 128'(dut.saved_q), 128'(0));
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Table: EMPTY-state behaviour for every valid/ready mix, no capture.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      b_exp = rand_beat();
      drive(vecs[i].ev, vecs[i].dr, vecs[i].rp, b_exp);
      @(negedge clock);
      chk($sformatf("vec%0d_deq_valid", i), 128'(deq_valid), 128'(vecs[i].exp_dv));
      chk($sformatf("vec%0d_enq_ready", i), 128'(enq_ready), 128'(vecs[i].exp_er));
      chk($sformatf("vec%0d_payload", i), 128'(deq_b), 128'(b_exp));
      next_cycle();
      chk($sformatf("vec%0d_full_next", i), 128'(full), 128'(vecs[i].exp_full_next));
    end

    // Passthrough of a Get.
    b_exp = mk_beat(A_GET, 31'h1000, 7'd5, 64'h0);
    drive(1'b1, 1'b1, 1'b0, b_exp);
    @(negedge clock);
    chk("pass_deq_valid", 128'(deq_valid), 128'(1'b1));
    chk("pass_payload", 128'(deq_b), 128'(b_exp));
    chk("pass_full", 128'(full), 128'(1'b0));
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, rand_beat());
    chk("pass_full_after", 128'(full), 128'(1'b0));

    // Capture and replay four times.
    b_exp = mk_beat(A_PUT_FULL, 31'h40, 7'd1, 64'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b1, b_exp);
    @(negedge clock);
    chk("cap_beat0", 128'(deq_b), 128'(b_exp));
    next_cycle();
    chk("cap_full", 128'(full), 128'(1'b1));
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, (k < 3), rand_beat());
      @(negedge clock);
      chk($sformatf("cap_enq_ready%0d", k), 128'(enq_ready), 128'(1'b0));
      chk($sformatf("cap_deq_valid%0d", k), 128'(deq_valid), 128'(1'b1));
      chk($sformatf("cap_beat%0d", k + 1), 128'(deq_b), 128'(b_exp));
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, rand_beat());
    chk("cap_released", 128'(full), 128'(1'b0));

    // Backpressure while held, upstream changing underneath.
    b_exp = rand_beat();
    drive(1'b1, 1'b1, 1'b1, b_exp);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, $urandom_range(0, 1), rand_beat());
      @(negedge clock);
      chk($sformatf("bp_payload%0d", k), 128'(deq_b), 128'(b_exp));
      chk($sformatf("bp_enq_ready%0d", k), 128'(enq_ready), 128'(1'b0));
      chk($sformatf("bp_deq_valid%0d", k), 128'(deq_valid), 128'(1'b1));
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, rand_beat());
    @(negedge clock);
    chk("bp_last_beat", 128'(deq_b), 128'(b_exp));
    next_cycle();
    chk("bp_released", 128'(full), 128'(1'b0));

    // Same-cycle pass-through and capture.
    b_exp = rand_beat();
    drive(1'b1, 1'b1, 1'b1, b_exp);
    @(negedge clock);
    chk("same_c0_valid", 128'(deq_valid), 128'(1'b1));
    chk("same_c0_beat", 128'(deq_b), 128'(b_exp));
    next_cycle();
    b_other = rand_beat();
    drive(1'b0, 1'b1, 1'b0, b_other);
    @(negedge clock);
    chk("same_c1_valid", 128'(deq_valid), 128'(1'b1));
    chk("same_c1_beat", 128'(deq_b), 128'(b_exp));
    next_cycle();
    chk("same_released", 128'(full), 128'(1'b0));

    // Asynchronous reset in the middle of a hold.
    b_exp = rand_beat();
    drive(1'b1, 1'b1, 1'b1, b_exp);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, rand_beat());
    chk("rst_held_before", 128'(full), 128'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_full_async", 128'(full), 128'(1'b0));
    chk("rst_deq_valid", 128'(deq_valid), 128'(1'b0));
    chk("rst_saved_zero", 128'(dut.saved_q), 128'(0));
    deq_ready = 1'b1;
    #1;
    chk("rst_enq_ready_follow", 128'(enq_ready), 128'(1'b1));
    next_cycle();
    reset = 1'b0;
    b_exp = rand_beat();
    drive(1'b1, 1'b1, 1'b0, b_exp);
    @(negedge clock);
    chk("rst_first_full", 128'(full), 128'(1'b0));
    chk("rst_first_pass", 128'(deq_b), 128'(b_exp));
    next_cycle();

    // Randomized traffic against the queue model, monitor enabled.
    held_q.delete();
    up_stall = 1'b0;
    mon_en   = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (up_stall) begin
        enq_valid = 1'b1;
      end else begin
        enq_valid = 1'($urandom_range(0, 1));
        drv       = rand_beat();
      end
      deq_ready = ($urandom_range(0, 3) != 0);
      rep       = ($urandom_range(0, 2) == 0);
      @(negedge clock);
      if (held_q.size() == 0) begin
        exp_dv = enq_valid;
        exp_er = deq_ready;
        b_exp  = drv;
      end else begin
        exp_dv = 1'b1;
        exp_er = 1'b0;
        b_exp  = held_q[0];
      end
      chk("rnd_deq_valid", 128'(deq_valid), 128'(exp_dv));
      chk("rnd_enq_ready", 128'(enq_ready), 128'(exp_er));
      chk("rnd_full", 128'(full), 128'(held_q.size() != 0));
      if (exp_dv) chk("rnd_payload", 128'(deq_b), 128'(b_exp));
      if (held_q.size() == 0) begin
        if (enq_valid && deq_ready && rep) held_q.push_back(drv);
      end else begin
        if (deq_ready && !rep) void'(held_q.pop_front());
      end
      up_stall = enq_valid && !exp_er;
      next_cycle();
    end
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
